// File: rtl/or32_result_checker.sv
// Scores a stream of (IN1, IN2, OUT) transactions against IN1|IN2 over a fixed-length session,
// keeping pass/fail counts and a snapshot of the first mismatching transaction.
module or32_result_checker #(
  parameter int WIDTH       = 32,
  parameter int NUM_VECTORS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             VALID,
  output logic             READY,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH-1:0] OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic [CNT_W-1:0] FIRST_FAIL_IDX,
  output logic [WIDTH-1:0] FIRST_FAIL_EXP,
  output logic [WIDTH-1:0] FIRST_FAIL_GOT
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Session length is tracked by its own counter so the end of a session does not
  // depend on CNT_W being wide enough to hold NUM_VECTORS.
  localparam int ACC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [ACC_W-1:0] LAST_ACC = ACC_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic             r_error;
  logic [CNT_W-1:0] r_ff_idx;
  logic [WIDTH-1:0] r_ff_exp;
  logic [WIDTH-1:0] r_ff_got;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_exp;
  logic [WIDTH-1:0] r_s1_got;
  logic [CNT_W-1:0] r_s1_idx;

  logic w_accept;
  logic w_last;

  assign READY          = (r_state == S_RUN);
  assign BUSY           = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign DONE           = (r_state == S_DONE);
  assign ERROR          = r_error;
  assign PASS_CNT       = r_pass;
  assign FAIL_CNT       = r_fail;
  assign FIRST_FAIL_IDX = r_ff_idx;
  assign FIRST_FAIL_EXP = r_ff_exp;
  assign FIRST_FAIL_GOT = r_ff_got;

  assign w_accept = VALID & READY;
  assign w_last   = (r_acc == LAST_ACC);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_idx      <= '0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_error    <= 1'b0;
      r_ff_idx   <= '0;
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_got   <= '0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_exp <= IN1 | IN2;
        r_s1_got <= OUT;
        r_s1_idx <= r_idx;
        r_acc    <= r_acc + 1'b1;
        if (r_idx != CNT_MAX) r_idx <= r_idx + 1'b1;
      end

      // An unknown operand or result falls through to the mismatch branch.
      if (r_s1_valid) begin
        if (r_s1_exp == r_s1_got) begin
          if (r_pass != CNT_MAX) r_pass <= r_pass + 1'b1;
        end else begin
          if (r_fail != CNT_MAX) r_fail <= r_fail + 1'b1;
          r_error <= 1'b1;
          if (r_fail == '0) begin
            r_ff_idx <= r_s1_idx;
            r_ff_exp <= r_s1_exp;
            r_ff_got <= r_s1_got;
          end
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state  <= S_RUN;
            r_acc    <= '0;
            r_idx    <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_error  <= 1'b0;
            r_ff_idx <= '0;
            r_ff_exp <= '0;
            r_ff_got <= '0;
          end
        end
        S_RUN:   if (w_accept && w_last) r_state <= S_DRAIN;
        S_DRAIN: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
